// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit: ALUop encodings
// and the controller state type.
package mdu_iter_pkg;

  localparam int ALUOP_WIDTH = 5;

  localparam logic [ALUOP_WIDTH-1:0] ALU_MUL  = 5'd15;
  localparam logic [ALUOP_WIDTH-1:0] ALU_DIV  = 5'd16;
  localparam logic [ALUOP_WIDTH-1:0] ALU_DIVU = 5'd17;
  localparam logic [ALUOP_WIDTH-1:0] ALU_REM  = 5'd18;
  localparam logic [ALUOP_WIDTH-1:0] ALU_REMU = 5'd19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIN  = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter_div_step.sv
// One restoring radix-2 division iteration: shift the next dividend bit into
// the partial remainder, subtract the divisor if it fits, emit one quotient bit.
module mdu_iter_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] rem_sh_s;
  logic [XLEN:0] diff_s;

  // trial subtraction with one extra bit so the borrow is the sign of diff_s
  always_comb begin
    rem_sh_s = {rem_in, quo_in[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, divisor};
    if (!diff_s[XLEN]) begin
      rem_out = diff_s[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = rem_sh_s[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready handshakes on both sides and flush.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ITER = XLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ALUOP_WIDTH-1:0] op,
  input  logic [XLEN-1:0]        src_a,
  input  logic [XLEN-1:0]        src_b,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        result,
  output logic                   busy
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

  mdu_state_t    state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  // acc: product (MUL) or partial remainder (DIV)
  // a:   multiplicand (MUL) or dividend/quotient shift register (DIV)
  // b:   multiplier (MUL) or divisor magnitude (DIV)
  logic [XLEN-1:0] acc_r, acc_s, a_r, a_s, b_r, b_s;
  logic            neg_q_r, neg_q_s, neg_r_r, neg_r_s, is_rem_r, is_rem_s;
  logic [XLEN-1:0] result_r, result_s;
  logic            out_valid_r, out_valid_s, in_ready_r, in_ready_s, busy_r, busy_s;

  logic [XLEN-1:0] mul_sum_s, step_rem_s, step_quo_s, fix_q_s, fix_r_s;
  logic            sgn_s, rem_op_s;

  mdu_iter_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (acc_r),
    .quo_in  (a_r),
    .divisor (b_r),
    .rem_out (step_rem_s),
    .quo_out (step_quo_s)
  );

  // next-state, datapath and output computation
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    acc_s       = acc_r;
    a_s         = a_r;
    b_s         = b_r;
    neg_q_s     = neg_q_r;
    neg_r_s     = neg_r_r;
    is_rem_s    = is_rem_r;
    result_s    = result_r;
    out_valid_s = out_valid_r;
    mul_sum_s   = b_r[0] ? (acc_r + a_r) : acc_r;
    fix_q_s     = neg_q_r ? (ZERO - step_quo_s) : step_quo_s;
    fix_r_s     = neg_r_r ? (ZERO - step_rem_s) : step_rem_s;
    sgn_s       = (op == ALU_DIV) || (op == ALU_REM);
    rem_op_s    = (op == ALU_REM) || (op == ALU_REMU);

    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r && !flush) begin
          case (op)
            ALU_MUL: begin
              state_s = ST_MUL;
              cnt_s   = CW'(ITER - 1);
              acc_s   = ZERO;
              a_s     = src_a;
              b_s     = src_b;
            end
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
              if (src_b == ZERO) begin
                state_s     = ST_FIN;
                result_s    = rem_op_s ? src_a : ALL_ONE;
                out_valid_s = 1'b1;
              end else if (sgn_s && (src_a == MIN_NEG) && (src_b == ALL_ONE)) begin
                state_s     = ST_FIN;
                result_s    = rem_op_s ? ZERO : src_a;
                out_valid_s = 1'b1;
              end else begin
                state_s  = ST_DIV;
                cnt_s    = CW'(ITER - 1);
                acc_s    = ZERO;
                a_s      = (sgn_s && src_a[XLEN-1]) ? (ZERO - src_a) : src_a;
                b_s      = (sgn_s && src_b[XLEN-1]) ? (ZERO - src_b) : src_b;
                neg_q_s  = sgn_s && (src_a[XLEN-1] ^ src_b[XLEN-1]);
                neg_r_s  = sgn_s && src_a[XLEN-1];
                is_rem_s = rem_op_s;
              end
            end
            default: begin
              state_s     = ST_FIN;
              result_s    = ZERO;
              out_valid_s = 1'b1;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_s     = ST_IDLE;
          out_valid_s = 1'b0;
        end else begin
          acc_s = mul_sum_s;
          a_s   = {a_r[XLEN-2:0], 1'b0};
          b_s   = {1'b0, b_r[XLEN-1:1]};
          if (cnt_r == CW'(0)) begin
            state_s     = ST_FIN;
            result_s    = mul_sum_s;
            out_valid_s = 1'b1;
          end else begin
            cnt_s = cnt_r - CW'(1);
          end
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_s     = ST_IDLE;
          out_valid_s = 1'b0;
        end else begin
          acc_s = step_rem_s;
          a_s   = step_quo_s;
          // sign fixup is applied to the last step's outputs on the way into FIN
          if (cnt_r == CW'(0)) begin
            state_s     = ST_FIN;
            result_s    = is_rem_r ? fix_r_s : fix_q_s;
            out_valid_s = 1'b1;
          end else begin
            cnt_s = cnt_r - CW'(1);
          end
        end
      end
      ST_FIN: begin
        if (flush || out_ready) begin
          state_s     = ST_IDLE;
          out_valid_s = 1'b0;
        end else begin
          state_s = ST_FIN;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        out_valid_s = 1'b0;
      end
    endcase

    in_ready_s = (state_s == ST_IDLE);
    busy_s     = (state_s != ST_IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      acc_r       <= ZERO;
      a_r         <= ZERO;
      b_r         <= ZERO;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      is_rem_r    <= 1'b0;
      result_r    <= ZERO;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      acc_r       <= acc_s;
      a_r         <= a_s;
      b_r         <= b_s;
      neg_q_r     <= neg_q_s;
      neg_r_r     <= neg_r_s;
      is_rem_r    <= is_rem_s;
      result_r    <= result_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: vector table plus hand-written
// backpressure, flush and asynchronous-reset sequences.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = 5'd0;
  logic [63:0] src_a = 64'd0;
  logic [63:0] src_b = 64'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.XLEN(64), .ITER(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // issue one op, wait for the result (bounded), then let write-back consume it
  task automatic do_op(input logic [4:0] o, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output int lat, output logic ir_bad);
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    tick();
    in_valid = 1'b0;
    src_a    = ~a;
    src_b    = ~b;
    lat      = 1;
    ir_bad   = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ir_bad = 1'b1;
      tick();
      lat++;
    end
    res = result;
    tick();
  endtask

  logic [63:0] res;
  int          lat;
  logic        ir_bad;
  logic [63:0] held;
  logic        bad;

  initial begin
    vecs[0]  = '{ALU_MUL,  64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vecs[1]  = '{ALU_DIV,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65};
    vecs[2]  = '{ALU_REM,  64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[3]  = '{ALU_DIVU, 64'd100, 64'd7, 64'd14, 65};
    vecs[4]  = '{ALU_REMU, 64'd100, 64'd7, 64'd2, 65};
    vecs[5]  = '{ALU_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[6]  = '{ALU_REM,  64'd5, 64'd0, 64'd5, 1};
    vecs[7]  = '{ALU_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[8]  = '{ALU_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[9]  = '{ALU_DIV,  64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 65};
    vecs[10] = '{ALU_REM,  64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 65};
    vecs[11] = '{ALU_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65};
    vecs[12] = '{ALU_MUL,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 65};
    vecs[13] = '{5'd3,     64'd9, 64'd4, 64'd0, 1};
    vecs[14] = '{ALU_REMU, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 65};
    vecs[15] = '{ALU_DIV,  64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};

    #12;
    chk("reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, ir_bad);
      chk($sformatf("vec%0d result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d in_ready low while busy", i), {63'd0, ir_bad}, 64'd0);
    end

    // backpressure: result must hold while write-back stalls
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = ALU_DIVU;
    src_a     = 64'd100;
    src_b     = 64'd7;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("bp latency", 64'(lat), 64'd65);
    chk("bp result", result, 64'd14);
    held = result;
    bad  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (result !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    chk("bp held stable", {63'd0, bad}, 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    chk("bp in_ready after consume", {63'd0, in_ready}, 64'd1);
    chk("bp out_valid after consume", {63'd0, out_valid}, 64'd0);
    chk("bp busy after consume", {63'd0, busy}, 64'd0);

    // flush in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1;
    op       = ALU_DIV;
    src_a    = 64'd1000;
    src_b    = 64'd7;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 29; k++) tick();
    @(negedge clk);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush busy", {63'd0, busy}, 64'd0);
    bad = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (out_valid) bad = 1'b1;
      tick();
    end
    chk("flush no out_valid", {63'd0, bad}, 64'd0);
    do_op(ALU_MUL, 64'd6, 64'd7, res, lat, ir_bad);
    chk("post-flush mul", res, 64'd42);
    chk("post-flush mul latency", 64'(lat), 64'd65);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    op       = ALU_DIVU;
    src_a    = 64'd9;
    src_b    = 64'd0;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("idle flush busy", {63'd0, busy}, 64'd0);
    chk("idle flush in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("idle flush out_valid", {63'd0, out_valid}, 64'd0);

    // asynchronous reset between clock edges in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1;
    op       = ALU_MUL;
    src_a    = 64'h1234;
    src_b    = 64'h10;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async reset in_ready", {63'd0, in_ready}, 64'd1);
    chk("async reset busy", {63'd0, busy}, 64'd0);
    chk("async reset out_valid", {63'd0, out_valid}, 64'd0);
    chk("async reset result", result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post-reset in_ready", {63'd0, in_ready}, 64'd1);
    do_op(ALU_MUL, 64'd123, 64'd456, res, lat, ir_bad);
    chk("post-reset mul", res, 64'd56088);
    chk("post-reset mul latency", 64'(lat), 64'd65);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
